// File: rtl/dds_pkg.sv
// Shared constants, scheduler state type and phase-to-address helper for the DDS ROM scheduler.
// Both the top-level scheduler and the per-channel accumulator import this package.
package dds_pkg;

    localparam int PHASE_W = 32;
    localparam int ADDR_W  = 11;
    localparam int ROM_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // The ROM is indexed by the top ADDR_W bits of the phase.
    function automatic logic [ADDR_W-1:0] phase_to_addr(input logic [PHASE_W-1:0] ph);
        return ADDR_W'(ph >> (PHASE_W - ADDR_W));
    endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// Single-channel phase accumulator with a shadow/active tuning-word pair; one cycle per update.
// No backpressure: shadow loads any time, the active word only moves on the frame-start transfer.
module dds_phase_acc
    import dds_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_load,
    input  logic               ftw_xfer,
    input  logic               clr,
    input  logic               adv,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] shadow_q, shadow_d;
    logic [PHASE_W-1:0] act_q,    act_d;
    logic [PHASE_W-1:0] phase_q,  phase_d;

    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        phase_d  = phase_q;

        if (ftw_load) begin
            shadow_d = ftw_in;
        end
        // The transfer takes the shadow as it stood before this cycle's load.
        if (ftw_xfer) begin
            act_d = shadow_q;
        end
        if (clr) begin
            phase_d = '0;
        end else if (adv) begin
            phase_d = phase_q + act_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            act_q    <= '0;
            phase_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            phase_q  <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/dds_rom_scheduler.sv
// Round-robin ROM address scheduler for NCH DDS channels: Address 1 cycle after tick, out_valid ROM_LAT later.
// No backpressure: ticks arriving while a frame is in flight are dropped and flagged in sticky overrun.
module dds_rom_scheduler
    import dds_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic                   Fg_CLK,
    input  logic                   RESET,
    input  logic                   enable,
    input  logic                   sample_tick,
    input  logic [NCH*PHASE_W-1:0] ftw_in,
    input  logic                   ftw_load,
    input  logic                   phase_clr,
    output logic [ADDR_W-1:0]      Address,
    output logic                   out_valid,
    output logic [1:0]             out_ch,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [1:0] LAST_CH    = 2'(NCH - 1);
    localparam logic [3:0] LAST_DRAIN = 4'(ROM_LAT - 1);

    sched_state_t      state_q, state_d;
    logic [1:0]        ch_idx_q, ch_idx_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overrun_q, overrun_d;
    logic              clr_pend_q, clr_pend_d;
    logic [ROM_LAT:0]  pipe_vld_q, pipe_vld_d;
    logic [1:0]        pipe_ch_q [ROM_LAT+1];
    logic [1:0]        pipe_ch_d [ROM_LAT+1];

    logic [PHASE_W-1:0] phase [NCH];
    logic [PHASE_W-1:0] next_phase;
    logic [1:0]         next_ch;
    logic [NCH-1:0]     adv;
    logic               start;
    logic               issue_next;
    logic               clr_now;

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        drain_cnt_d = drain_cnt_q;
        addr_d      = addr_q;
        overrun_d   = overrun_q;
        clr_pend_d  = clr_pend_q;
        start       = 1'b0;
        issue_next  = 1'b0;
        clr_now     = 1'b0;
        next_ch     = ch_idx_q;
        next_phase  = '0;
        adv         = '0;

        case (state_q)
            IDLE: begin
                // A deferred clear lands here, ahead of any tick in the same cycle.
                clr_now    = phase_clr | clr_pend_q;
                clr_pend_d = 1'b0;
                if (sample_tick && enable) begin
                    start      = 1'b1;
                    issue_next = 1'b1;
                    next_ch    = 2'd0;
                    ch_idx_d   = 2'd0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (phase_clr) clr_pend_d = 1'b1;
                if (sample_tick && enable) overrun_d = 1'b1;
                if (ch_idx_q == LAST_CH) begin
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    issue_next = 1'b1;
                    next_ch    = ch_idx_q + 2'd1;
                    ch_idx_d   = next_ch;
                end
            end
            DRAIN: begin
                if (phase_clr) clr_pend_d = 1'b1;
                if (sample_tick && enable) overrun_d = 1'b1;
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < NCH; i++) begin
            adv[i] = (state_q == ISSUE) && (ch_idx_q == 2'(i));
            if (next_ch == 2'(i)) next_phase = phase[i];
        end

        // Address is registered on the edge that enters each channel's issue slot.
        if (issue_next) begin
            addr_d = clr_now ? '0 : phase_to_addr(next_phase);
        end

        pipe_vld_d   = {pipe_vld_q[ROM_LAT-1:0], issue_next};
        pipe_ch_d[0] = issue_next ? next_ch : 2'd0;
        for (int s = 1; s <= ROM_LAT; s++) begin
            pipe_ch_d[s] = pipe_ch_q[s-1];
        end
    end

    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            ch_idx_q    <= '0;
            drain_cnt_q <= '0;
            addr_q      <= '0;
            overrun_q   <= 1'b0;
            clr_pend_q  <= 1'b0;
            pipe_vld_q  <= '0;
            for (int s = 0; s <= ROM_LAT; s++) begin
                pipe_ch_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            drain_cnt_q <= drain_cnt_d;
            addr_q      <= addr_d;
            overrun_q   <= overrun_d;
            clr_pend_q  <= clr_pend_d;
            pipe_vld_q  <= pipe_vld_d;
            for (int s = 0; s <= ROM_LAT; s++) begin
                pipe_ch_q[s] <= pipe_ch_d[s];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_acc
        dds_phase_acc u_acc (
            .clk      (Fg_CLK),
            .rst      (RESET),
            .ftw_in   (ftw_in[g*PHASE_W +: PHASE_W]),
            .ftw_load (ftw_load),
            .ftw_xfer (start),
            .clr      (clr_now),
            .adv      (adv[g]),
            .phase    (phase[g])
        );
    end

    assign Address   = addr_q;
    assign out_valid = pipe_vld_q[ROM_LAT];
    assign out_ch    = pipe_ch_q[ROM_LAT];
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule
